// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC sample scheduler: state encoding,
// interface widths and the saturating event-counter increment.
package adc_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = 5;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        WAIT_RSP = 2'd2,
        NEXT     = 2'd3
    } adc_state_e;

    // Increment that sticks at all-ones so event counters never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_rate_tick.sv
// Frame-rate divider: counts 0..DIV-1 while enabled and flags the last
// count as the frame tick. Disabling holds the count at zero, so the first
// tick after enabling always arrives a full DIV cycles later.
module adc_rate_tick #(
    parameter int DIV = 6250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_r;

    // Rate counter: wraps at DIV-1, cleared while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (!en) begin
            count_r <= '0;
        end else if (count_r == LAST) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign tick = (count_r == LAST) && en;

endmodule

// File: rtl/adc_sample_scheduler.sv
// Paces the modular ADC at a fixed frame rate: each tick converts channels
// CH_BASE..CH_BASE+NUM_CH-1 in turn, forwards matching results as one-cycle
// samples and keeps saturating counts of overruns, timeouts and mismatches.
module adc_sample_scheduler
    import adc_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int SAMPLE_HZ   = 8000,
    parameter int NUM_CH      = 1,
    parameter int CH_BASE     = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  cmd_valid,
    output logic [ADC_CH_W-1:0]   cmd_channel,
    output logic                  cmd_sop,
    output logic                  cmd_eop,
    input  logic                  cmd_ready,
    input  logic                  rsp_valid,
    input  logic [ADC_CH_W-1:0]   rsp_channel,
    input  logic [ADC_DATA_W-1:0] rsp_data,
    output logic                  sample_valid,
    output logic [ADC_DATA_W-1:0] sample_data,
    output logic [ADC_CH_W-1:0]   sample_channel,
    output logic                  frame_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      overrun_cnt,
    output logic [CNT_W-1:0]      timeout_cnt,
    output logic [CNT_W-1:0]      mismatch_cnt
);

    localparam int DIV  = CLK_HZ / SAMPLE_HZ;
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]          IDX_LAST = 2'(NUM_CH - 1);
    localparam logic [ADC_CH_W-1:0] CH_FIRST = ADC_CH_W'(CH_BASE);

    if (DIV < 2) begin : g_chk_div
        $error("adc_sample_scheduler: CLK_HZ/SAMPLE_HZ must be at least 2");
    end
    if ((NUM_CH < 1) || (NUM_CH > 4)) begin : g_chk_num_ch
        $error("adc_sample_scheduler: NUM_CH must be 1..4");
    end
    if (CH_BASE + NUM_CH - 1 > 16) begin : g_chk_ch_range
        $error("adc_sample_scheduler: last channel exceeds 16");
    end
    if (TIMEOUT_CYC < 2) begin : g_chk_timeout
        $error("adc_sample_scheduler: TIMEOUT_CYC must be at least 2");
    end

    adc_state_e            state_r, state_s;
    logic [1:0]            idx_r, idx_s;
    logic [TO_W-1:0]       to_cnt_r;
    logic                  tick_s;
    logic [ADC_CH_W-1:0]   exp_ch_s;
    logic                  rsp_match_s, rsp_mismatch_s, timeout_s;

    logic                  cmd_valid_r, sample_valid_r, frame_done_r, busy_r;
    logic [ADC_CH_W-1:0]   cmd_channel_r, sample_channel_r;
    logic [ADC_DATA_W-1:0] sample_data_r;
    logic [CNT_W-1:0]      overrun_cnt_r, timeout_cnt_r, mismatch_cnt_r;

    adc_rate_tick #(.DIV(DIV)) u_rate_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick_s)
    );

    assign exp_ch_s = CH_FIRST + {3'b000, idx_r};

    // Next-state logic plus classification of the response seen in WAIT_RSP.
    always_comb begin
        state_s        = state_r;
        idx_s          = idx_r;
        rsp_match_s    = 1'b0;
        rsp_mismatch_s = 1'b0;
        timeout_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    idx_s   = 2'd0;
                    state_s = CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            CMD: begin
                if (cmd_ready) begin
                    state_s = WAIT_RSP;
                end else begin
                    state_s = CMD;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid && (rsp_channel == exp_ch_s)) begin
                    rsp_match_s = 1'b1;
                    state_s     = NEXT;
                end else begin
                    rsp_mismatch_s = rsp_valid;
                    if (to_cnt_r == TO_LAST) begin
                        timeout_s = 1'b1;
                        state_s   = NEXT;
                    end else begin
                        state_s = WAIT_RSP;
                    end
                end
            end
            NEXT: begin
                if (idx_r == IDX_LAST) begin
                    state_s = IDLE;
                end else begin
                    idx_s   = idx_r + 2'd1;
                    state_s = CMD;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 2'd0;
            end
        endcase
    end

    // State and channel-index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Response timeout counter, restarted when a command is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_r <= '0;
        end else if ((state_r == CMD) && cmd_ready) begin
            to_cnt_r <= '0;
        end else if (state_r == WAIT_RSP) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Command and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid_r   <= 1'b0;
            cmd_channel_r <= '0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            cmd_valid_r   <= (state_s == CMD);
            cmd_channel_r <= (state_s == CMD) ? (CH_FIRST + {3'b000, idx_s}) : '0;
            busy_r        <= (state_s != IDLE);
            frame_done_r  <= (state_s == NEXT) && (idx_s == IDX_LAST);
        end
    end

    // Sample output: one-cycle pulse, data held until the next match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_valid_r   <= 1'b0;
            sample_data_r    <= '0;
            sample_channel_r <= '0;
        end else begin
            sample_valid_r <= rsp_match_s;
            if (rsp_match_s) begin
                sample_data_r    <= rsp_data;
                sample_channel_r <= rsp_channel;
            end else begin
                sample_data_r    <= sample_data_r;
                sample_channel_r <= sample_channel_r;
            end
        end
    end

    // Saturating error counters; a tick arriving outside IDLE is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_cnt_r  <= '0;
            timeout_cnt_r  <= '0;
            mismatch_cnt_r <= '0;
        end else begin
            overrun_cnt_r  <= (tick_s && (state_r != IDLE)) ? sat_inc(overrun_cnt_r) : overrun_cnt_r;
            timeout_cnt_r  <= timeout_s ? sat_inc(timeout_cnt_r) : timeout_cnt_r;
            mismatch_cnt_r <= rsp_mismatch_s ? sat_inc(mismatch_cnt_r) : mismatch_cnt_r;
        end
    end

    assign cmd_valid      = cmd_valid_r;
    assign cmd_channel    = cmd_channel_r;
    assign cmd_sop        = cmd_valid_r;
    assign cmd_eop        = cmd_valid_r;
    assign sample_valid   = sample_valid_r;
    assign sample_data    = sample_data_r;
    assign sample_channel = sample_channel_r;
    assign frame_done     = frame_done_r;
    assign busy           = busy_r;
    assign overrun_cnt    = overrun_cnt_r;
    assign timeout_cnt    = timeout_cnt_r;
    assign mismatch_cnt   = mismatch_cnt_r;

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
- Paces the on-chip modular ADC at a fixed audio sample rate for the fingerprinting front end.
- Each rate tick issues one conversion command per configured channel, then waits for the matching response.
- Forwards each result as a registered, one-cycle-valid sample and counts overruns, timeouts and channel mismatches.
- Sits between the ADC IP command/response interface and the sample consumer (FIFO/FFT framer).

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- SAMPLE_HZ, 8000, frame (tick) rate. DIV = CLK_HZ/SAMPLE_HZ, integer, must be ≥ 2.
- NUM_CH, 1, channels converted per tick (1..4).
- CH_BASE, 1, first ADC channel. The frame converts channels CH_BASE..CH_BASE+NUM_CH-1.
- TIMEOUT_CYC, 1024, maximum cycles to wait for a response.

Ports:
- clk  in  1  system clock, same clock as the ADC IP clock_clk.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  enable sampling.
- cmd_valid  out  1  command valid to ADC.
- cmd_channel  out  5  channel for the command.
- cmd_sop  out  1  equals cmd_valid.
- cmd_eop  out  1  equals cmd_valid.
- cmd_ready  in  1  ADC accepts the command.
- rsp_valid  in  1  ADC response valid.
- rsp_channel  in  5  response channel.
- rsp_data  in  12  conversion result.
- sample_valid  out  1  one-cycle pulse.
- sample_data  out  12  registered result.
- sample_channel  out  5  channel of sample_data.
- frame_done  out  1  pulse on the cycle the last channel of a frame completes or times out.
- busy  out  1  high when state ≠ IDLE.
- overrun_cnt  out  16  saturating count of dropped ticks.
- timeout_cnt  out  16  saturating count of response timeouts.
- mismatch_cnt  out  16  saturating count of wrong-channel responses.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; the rate counter and channel index clear to 0.
  - All outputs go to 0 and all counters go to 0.
  - This applies even mid-command: cmd_valid drops on the next cycle.
- Rate counter:
  - While en=1 it counts 0..DIV-1 and wraps.
  - tick = (count==DIV-1) && en.
  - While en=0 it holds at 0, so the first tick comes DIV cycles after en rises.
- FSM IDLE:
  - On tick, set idx=0 and go to CMD.
- FSM CMD:
  - cmd_valid=1, cmd_channel=CH_BASE+idx.
  - Hold both stable until cmd_ready=1 is sampled, then go to WAIT_RSP and clear the timeout counter.
  - No timeout applies in CMD.
- FSM WAIT_RSP:
  - rsp_valid with rsp_channel==expected: the next cycle gives sample_valid=1, sample_data=rsp_data, sample_channel=rsp_channel (1-cycle latency). Go to NEXT.
  - rsp_valid with the wrong channel: discard the data, increment mismatch_cnt, stay in WAIT_RSP. The timeout counter continues.
  - Timeout counter reaches TIMEOUT_CYC-1 without a matching response: increment timeout_cnt, emit no sample, go to NEXT.
- FSM NEXT (one cycle):
  - If idx==NUM_CH-1: pulse frame_done and go to IDLE.
  - Otherwise: idx+1 and go to CMD.
- rsp_valid in IDLE/CMD/NEXT is ignored and not counted.
- Tick while busy: the tick is dropped, overrun_cnt increments, and the frame in progress continues undisturbed.
- en falls mid-frame: the current frame completes (including pending responses). Only new ticks are suppressed.
- Tick coincident with frame_done (state NEXT, last channel): counts as overrun, because the FSM is not yet IDLE.
- All counters saturate at 16'hFFFF and never wrap.
- cmd_sop and cmd_eop are tied to cmd_valid: each command is a single-beat packet.
- Elaboration checks: DIV≥2, 1≤NUM_CH≤4, CH_BASE+NUM_CH-1≤16, TIMEOUT_CYC≥2.

Decomposition:
- Package adc_pkg holds:
  - state encoding (IDLE, CMD, WAIT_RSP, NEXT);
  - ADC_DATA_W=12, ADC_CH_W=5, CNT_W=16;
  - the saturating-increment function.
- One sub-module: adc_rate_tick (parameter DIV; ports clk, rst_n, en, tick).
- The FSM, response checking and counters stay in the top module.

Test Plan:
All scenarios use DIV=20, NUM_CH=2, CH_BASE=1, TIMEOUT_CYC=8.
- Basic frame:
  - Stimulus: rst_n low 3 cycles, en=1. cmd_ready high; ADC model answers 4 cycles after each accepted command with data 0x123 (ch1) and 0xABC (ch2).
  - Response: first cmd_valid in cycle 20 after en (ch1), then ch2; samples arrive in order with correct channel; one frame_done; every frame repeats at a 20-cycle period.
- Ready backpressure:
  - Stimulus: hold cmd_ready=0 for 5 cycles.
  - Response: cmd_valid and cmd_channel stay stable throughout; exactly one command is accepted.
- Timeout:
  - Stimulus: the model never responds to ch1.
  - Response: timeout_cnt=1 after 8 cycles in WAIT_RSP; no ch1 sample; ch2 is still converted; frame_done pulses.
- Channel mismatch:
  - Stimulus: respond on ch3, then on ch1 with 0x055.
  - Response: mismatch_cnt=1; exactly one sample (ch1, 0x055).
- Overrun:
  - Stimulus: response delay of 15 cycles, so the frame exceeds 20 cycles.
  - Response: overrun_cnt increments once per dropped tick; no frame is aborted; sample order is preserved.
- Reset mid-operation:
  - Stimulus: pull rst_n low while in WAIT_RSP.
  - Response: next cycle busy=0, cmd_valid=0, all counters 0; the late response arriving after reset is ignored.
